// File: rtl/div_seq_ctrl_if.sv
// Request/response channel between the EX stage (master) and the divide
// sequencing controller (slave).
interface div_seq_ctrl_if #(
  parameter int DW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_src1;
  logic [DW-1:0] req_src2;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_src1, req_src2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer between the EX stage and a multi-cycle divider: zero-divisor
// short-circuit, flush abort, timeout guard. Define DIV_RESULT_REUSE_EN to reuse the last divider result.
module div_seq_ctrl #(
  parameter int DW         = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          flush,
  div_seq_ctrl_if.slave pipe,
  output logic          busy,
  output logic          timeout_err,
  output logic          div_en,
  output logic          div_signed,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  input  logic [DW-1:0] div_quotient,
  input  logic [DW-1:0] div_remainder,
  input  logic          div_complete
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CntMax = 8'(MAX_CYCLES);

  state_t        state_q, state_d;
  logic          isMod_q, isMod_d;
  logic          signed_q, signed_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic [DW-1:0] result_q, result_d;
  logic [7:0]    cycleCnt_q, cycleCnt_d;
  logic          timeoutErr_q, timeoutErr_d;

  logic          accept;
  logic          zeroDiv;
  logic [DW-1:0] zeroResult;
  logic          cacheHit;
  logic [DW-1:0] cacheResult;

  assign accept     = pipe.req_valid & (state_q == IDLE) & ~flush;
  assign zeroDiv    = (pipe.req_src2 == '0);
  assign zeroResult = pipe.req_op[0] ? pipe.req_src1 : '1;

`ifdef DIV_RESULT_REUSE_EN
  logic          cacheValid_q, cacheValid_d;
  logic          cacheSigned_q, cacheSigned_d;
  logic [DW-1:0] cacheSrc1_q, cacheSrc1_d;
  logic [DW-1:0] cacheSrc2_q, cacheSrc2_d;
  logic [DW-1:0] cacheQuot_q, cacheQuot_d;
  logic [DW-1:0] cacheRem_q, cacheRem_d;
  logic          divDone;
  logic          divTimeout;

  assign divDone    = (state_q == BUSY) & ~flush & div_complete;
  assign divTimeout = (state_q == BUSY) & ~flush & ~div_complete & (cycleCnt_q >= CntMax);

  // Signedness must match, but DIV/MOD may differ since both results are kept.
  assign cacheHit    = cacheValid_q & (cacheSrc1_q == pipe.req_src1) &
                       (cacheSrc2_q == pipe.req_src2) & (cacheSigned_q == ~pipe.req_op[1]);
  assign cacheResult = pipe.req_op[0] ? cacheRem_q : cacheQuot_q;

  always_comb begin
    cacheValid_d  = cacheValid_q;
    cacheSigned_d = cacheSigned_q;
    cacheSrc1_d   = cacheSrc1_q;
    cacheSrc2_d   = cacheSrc2_q;
    cacheQuot_d   = cacheQuot_q;
    cacheRem_d    = cacheRem_q;
    if ((flush && state_q != IDLE) || divTimeout) begin
      cacheValid_d = 1'b0;
    end else if (divDone) begin
      cacheValid_d  = 1'b1;
      cacheSigned_d = signed_q;
      cacheSrc1_d   = dividend_q;
      cacheSrc2_d   = divisor_q;
      cacheQuot_d   = div_quotient;
      cacheRem_d    = div_remainder;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cacheValid_q  <= 1'b0;
      cacheSigned_q <= 1'b0;
      cacheSrc1_q   <= '0;
      cacheSrc2_q   <= '0;
      cacheQuot_q   <= '0;
      cacheRem_q    <= '0;
    end else begin
      cacheValid_q  <= cacheValid_d;
      cacheSigned_q <= cacheSigned_d;
      cacheSrc1_q   <= cacheSrc1_d;
      cacheSrc2_q   <= cacheSrc2_d;
      cacheQuot_q   <= cacheQuot_d;
      cacheRem_q    <= cacheRem_d;
    end
  end
`else
  assign cacheHit    = 1'b0;
  assign cacheResult = '0;
`endif

  // Flush outranks everything; completion outranks the timeout check.
  always_comb begin
    state_d      = state_q;
    isMod_d      = isMod_q;
    signed_d     = signed_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    result_d     = result_q;
    cycleCnt_d   = cycleCnt_q;
    timeoutErr_d = timeoutErr_q;
    if (flush) begin
      state_d    = IDLE;
      cycleCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            isMod_d    = pipe.req_op[0];
            signed_d   = ~pipe.req_op[1];
            dividend_d = pipe.req_src1;
            divisor_d  = pipe.req_src2;
            if (zeroDiv) begin
              state_d  = DONE;
              result_d = zeroResult;
            end else if (cacheHit) begin
              state_d  = DONE;
              result_d = cacheResult;
            end else begin
              state_d    = BUSY;
              cycleCnt_d = 8'd1;
            end
          end
        end
        BUSY: begin
          if (div_complete) begin
            state_d  = DONE;
            result_d = isMod_q ? div_remainder : div_quotient;
          end else if (cycleCnt_q >= CntMax) begin
            state_d      = DONE;
            result_d     = '0;
            timeoutErr_d = 1'b1;
          end else begin
            cycleCnt_d = cycleCnt_q + 8'd1;
          end
        end
        DONE: begin
          if (pipe.resp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      isMod_q      <= 1'b0;
      signed_q     <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      result_q     <= '0;
      cycleCnt_q   <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      isMod_q      <= isMod_d;
      signed_q     <= signed_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      result_q     <= result_d;
      cycleCnt_q   <= cycleCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign pipe.req_ready  = (state_q == IDLE);
  assign pipe.resp_valid = (state_q == DONE);
  assign pipe.resp_data  = result_q;
  assign busy            = (state_q != IDLE);
  assign div_en          = (state_q == BUSY);
  assign div_signed      = signed_q;
  assign div_dividend    = dividend_q;
  assign div_divisor     = divisor_q;
  assign timeout_err     = timeoutErr_q;

endmodule
